// File: rtl/ram_access_ctrl_if.sv
// Request/response channels between the CPU load/store path and ram_access_ctrl.
// The master drives requests and accepts responses; the slave is the controller.
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_last
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Sequences single-beat writes and 1..2^LEN_W beat read bursts onto a
// synchronous-read RAM, absorbing its one-cycle read latency.
module ram_access_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_access_ctrl_if.slave     bus,
  output logic                 ram_write,
  output logic                 ram_read,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic               is_write_q, is_write_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               ram_write_d, ram_read_d;
  logic [ADDR_W-1:0]  ram_addr_d;
  logic [DATA_W-1:0]  ram_wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_last_q, rsp_last_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_d     = state_q;
    is_write_d  = is_write_q;
    remaining_d = remaining_q;
    ram_write_d = 1'b0;
    ram_read_d  = 1'b0;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    rsp_valid_d = rsp_valid_q;
    rsp_last_d  = rsp_last_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          ram_addr_d  = bus.req_addr;
          ram_wdata_d = bus.req_wdata;
          is_write_d  = bus.req_write;
          remaining_d = bus.req_write ? '0 : bus.req_len;
          ram_write_d = bus.req_write;
          ram_read_d  = !bus.req_write;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // A write is complete once its strobe has been seen, so it acks
        // straight away; a read must wait for the RAM output register.
        if (is_write_q) begin
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b1;
          state_d     = RESP;
        end else begin
          state_d     = WAIT;
        end
      end
      WAIT: begin
        rsp_rdata_d = ram_rdata;
        rsp_valid_d = 1'b1;
        rsp_last_d  = (remaining_q == '0);
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - 1'b1;
            ram_addr_d  = ram_addr + 1'b1;
            ram_read_d  = 1'b1;
            state_d     = ISSUE;
          end else begin
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      remaining_q <= '0;
      ram_write   <= 1'b0;
      ram_read    <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      remaining_q <= remaining_d;
      ram_write   <= ram_write_d;
      ram_read    <= ram_read_d;
      ram_addr    <= ram_addr_d;
      ram_wdata   <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 64x16 synchronous-read
// RAM preloaded with mem[a] = 3*a + 7.
module tb_ram_access_ctrl;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ram_write, ram_read, busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int vectors = 0;
  int miscompares = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int strobe_errs = 0;

  ram_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  ram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_write (ram_write),
    .ram_read  (ram_read),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // RAM model, loaded on the first edge (which falls inside reset).
  logic [DATA_W-1:0] mem [64];
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'(3 * i + 7);
      ram_loaded <= 1'b1;
    end else begin
      if (ram_write) mem[ram_addr] <= ram_wdata;
      if (ram_read)  ram_rdata <= mem[ram_addr];
    end
  end

  // Strobe monitor: pulse counts and illegal strobe combinations.
  always @(posedge clk) begin
    #2;
    if (ram_write) wr_pulses <= wr_pulses + 1;
    if (ram_read)  rd_pulses <= rd_pulses + 1;
    if ((ram_write && ram_read) || ((ram_write || ram_read) && (bus.rsp_valid || !busy)))
      strobe_errs <= strobe_errs + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic accept(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] wdata,
                        input string name);
    logic ok;
    bit   done;
    done = 1'b0;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      ok = bus.req_ready;
      @(posedge clk); #1;
      if (ok === 1'b1) done = 1'b1;
    end
    bus.req_valid = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s accept: got no req_ready want accept within 50 cycles", name);
    end
  endtask

  // Waits (bounded) for rsp_valid and checks the beat's latency, data and last flag.
  task automatic wait_beat(input logic [DATA_W-1:0] exp_data, input logic exp_last,
                           input int exp_lat, input string name);
    int n;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges want %0d", name, n, exp_lat);
    end
    vectors++;
    if (bus.rsp_rdata !== exp_data) begin
      miscompares++;
      $display("FAIL %s rdata: got %h want %h", name, bus.rsp_rdata, exp_data);
    end
    vectors++;
    if (bus.rsp_last !== exp_last) begin
      miscompares++;
      $display("FAIL %s last: got %b want %b", name, bus.rsp_last, exp_last);
    end
  endtask

  task automatic handshake();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, bus.req_ready, bus.rsp_valid, bus.rsp_last, ram_read, ram_write} !== 6'b010000) begin
      miscompares++;
      $display("FAIL reset flags: got %b want 010000",
               {busy, bus.req_ready, bus.rsp_valid, bus.rsp_last, ram_read, ram_write});
    end
    vectors++;
    if ({bus.rsp_rdata, ram_addr, ram_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset regs: got rdata=%h addr=%h wdata=%h want all 0",
               bus.rsp_rdata, ram_addr, ram_wdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    int rd0;
    rd0 = rd_pulses;
    bus.rsp_ready = 1'b1;
    accept(1'b0, 6'd5, 2'd0, 16'h0000, "single_read");
    vectors++;
    if ({ram_read, ram_write, ram_addr} !== {1'b1, 1'b0, 6'd5}) begin
      miscompares++;
      $display("FAIL single_read issue: got rd=%b wr=%b addr=%0d want rd=1 wr=0 addr=5",
               ram_read, ram_write, ram_addr);
    end
    wait_beat(16'd22, 1'b1, 2, "single_read");
    handshake();
    vectors++;
    if ({bus.req_ready, busy, bus.rsp_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL single_read idle: got ready/busy/valid=%b want 100",
               {bus.req_ready, busy, bus.rsp_valid});
    end
    vectors++;
    if (rd_pulses - rd0 !== 1) begin
      miscompares++;
      $display("FAIL single_read pulses: got %0d want 1", rd_pulses - rd0);
    end
  endtask

  task automatic test_burst_wrap();
    logic [DATA_W-1:0] exp_data [4];
    logic [ADDR_W-1:0] a;
    exp_data = '{16'd193, 16'd196, 16'd7, 16'd10};
    bus.rsp_ready = 1'b1;
    accept(1'b0, 6'd62, 2'd3, 16'h0000, "burst");
    for (int i = 0; i < 4; i++) begin
      a = 6'(62 + i);
      wait_beat(exp_data[i], (i == 3), 2, "burst");
      vectors++;
      if (ram_addr !== a) begin
        miscompares++;
        $display("FAIL burst addr beat %0d: got %0d want %0d", i, ram_addr, a);
      end
      handshake();
      if (i < 3) begin
        vectors++;
        if ({bus.rsp_valid, ram_read} !== 2'b01) begin
          miscompares++;
          $display("FAIL burst next issue beat %0d: got valid/read=%b want 01",
                   i, {bus.rsp_valid, ram_read});
        end
      end
    end
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL burst end ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_write_then_read();
    int wr0;
    wr0 = wr_pulses;
    bus.rsp_ready = 1'b1;
    accept(1'b1, 6'd10, 2'd3, 16'hBEEF, "write");
    vectors++;
    if ({ram_write, ram_read, ram_addr, ram_wdata} !== {1'b1, 1'b0, 6'd10, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL write issue: got wr=%b rd=%b addr=%0d wdata=%h want 1 0 10 beef",
               ram_write, ram_read, ram_addr, ram_wdata);
    end
    wait_beat(16'd10, 1'b1, 1, "write_ack");
    handshake();
    vectors++;
    if (wr_pulses - wr0 !== 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL write pulses/idle: got pulses=%0d busy=%b want 1 0",
               wr_pulses - wr0, busy);
    end
    accept(1'b0, 6'd10, 2'd0, 16'h0000, "read_back");
    wait_beat(16'hBEEF, 1'b1, 2, "read_back");
    handshake();
  endtask

  task automatic test_backpressure();
    int rd0;
    bus.rsp_ready = 1'b0;
    accept(1'b0, 6'd0, 2'd1, 16'h0000, "stall");
    wait_beat(16'd7, 1'b0, 2, "stall_b1");
    rd0 = rd_pulses;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({bus.rsp_valid, bus.rsp_last, bus.rsp_rdata, ram_read, ram_write} !==
          {1'b1, 1'b0, 16'd7, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL stall cycle %0d: got valid=%b last=%b rdata=%h rd=%b wr=%b want 1 0 0007 0 0",
                 i, bus.rsp_valid, bus.rsp_last, bus.rsp_rdata, ram_read, ram_write);
      end
    end
    vectors++;
    if (rd_pulses !== rd0) begin
      miscompares++;
      $display("FAIL stall strobes: got %0d reads want 0", rd_pulses - rd0);
    end
    bus.rsp_ready = 1'b1;
    handshake();
    wait_beat(16'd10, 1'b1, 2, "stall_b2");
    handshake();
  endtask

  task automatic test_hold_request();
    bus.rsp_ready = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 6'd62;
    bus.req_len   = 2'd1;
    bus.req_valid = 1'b1;
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold idle ready: got %b want 1", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_addr = 6'd3;
    bus.req_len  = 2'd0;
    vectors++;
    if ({bus.req_ready, busy, ram_addr} !== {1'b0, 1'b1, 6'd62}) begin
      miscompares++;
      $display("FAIL hold first: got ready=%b busy=%b addr=%0d want 0 1 62",
               bus.req_ready, busy, ram_addr);
    end
    wait_beat(16'd193, 1'b0, 2, "hold_b1");
    vectors++;
    if (bus.req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL hold resp ready: got %b want 0", bus.req_ready);
    end
    handshake();
    vectors++;
    if ({bus.req_ready, ram_addr} !== {1'b0, 6'd63}) begin
      miscompares++;
      $display("FAIL hold beat2 issue: got ready=%b addr=%0d want 0 63", bus.req_ready, ram_addr);
    end
    wait_beat(16'd196, 1'b1, 2, "hold_b2");
    handshake();
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold back to idle: got ready=%b want 1", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    vectors++;
    if ({ram_read, ram_addr} !== {1'b1, 6'd3}) begin
      miscompares++;
      $display("FAIL hold second accept: got rd=%b addr=%0d want 1 3", ram_read, ram_addr);
    end
    wait_beat(16'd16, 1'b1, 2, "hold_second");
    handshake();
  endtask

  // Asserts reset between clock edges and checks the outputs fall without a clock.
  task automatic pulse_reset_check(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ram_read, ram_write, bus.rsp_valid, bus.rsp_last, busy, bus.req_ready} !== 6'b000001) begin
      miscompares++;
      $display("FAIL %s flags: got %b want 000001", name,
               {ram_read, ram_write, bus.rsp_valid, bus.rsp_last, busy, bus.req_ready});
    end
    vectors++;
    if ({bus.rsp_rdata, ram_addr} !== '0) begin
      miscompares++;
      $display("FAIL %s regs: got rdata=%h addr=%0d want 0 0", name, bus.rsp_rdata, ram_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b1;
    accept(1'b0, 6'd20, 2'd3, 16'h0000, "rst_issue");
    pulse_reset_check("rst_issue");
    accept(1'b0, 6'd0, 2'd3, 16'h0000, "rst_wait");
    @(posedge clk); #1;
    vectors++;
    if ({busy, ram_read, bus.rsp_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_wait pre: got busy/rd/valid=%b want 100", {busy, ram_read, bus.rsp_valid});
    end
    pulse_reset_check("rst_wait");
    bus.rsp_ready = 1'b0;
    accept(1'b0, 6'd1, 2'd0, 16'h0000, "rst_resp");
    wait_beat(16'd10, 1'b1, 2, "rst_resp");
    pulse_reset_check("rst_resp");
    bus.rsp_ready = 1'b1;
    accept(1'b0, 6'd3, 2'd0, 16'h0000, "after_rst");
    wait_beat(16'd16, 1'b1, 2, "after_rst");
    handshake();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_wrap();
    test_write_then_read();
    test_backpressure();
    test_hold_request();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #3;
    vectors++;
    if (strobe_errs !== 0) begin
      miscompares++;
      $display("FAIL strobe_rules: got %0d violating cycles want 0", strobe_errs);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Upstream controller between the CPU load/store path and the 64x16 synchronous-read RAM.
- Accepts single-beat writes and 1-4 beat sequential read bursts over a valid/ready request channel.
- Sequences the RAM `write`/`read`/`addr`/`data_in` strobes and absorbs the RAM's 1-cycle read latency.
- Returns read data on a valid/ready response channel with backpressure.

Parameters:
- ADDR_W, 6, RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, data width.
- LEN_W, 2, burst length field width; beats = req_len+1, so 1..4 with the default.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  start address.
- req_len  in  LEN_W  read beats minus 1; ignored for writes.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  consumer accepts the beat.
- rsp_rdata  out  DATA_W  read data; holds its previous value on a write ack.
- rsp_last  out  1  final beat of the transaction.
- ram_write  out  1  drives RAM `write`.
- ram_read  out  1  drives RAM `read`.
- ram_addr  out  ADDR_W  drives RAM `addr`.
- ram_wdata  out  DATA_W  drives RAM `data_in`.
- ram_rdata  in  DATA_W  from RAM `data_out`.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- All outputs are registered except req_ready and busy, which decode directly from the state register.
- Reset, asynchronous and immediate, including mid-transaction:
  - state=IDLE.
  - ram_write=0, ram_read=0, ram_addr=0, ram_wdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_last=0.
  - Beat counter=0.
  - req_ready=1, busy=0 after reset.
  - RAM contents are untouched; an in-flight response is dropped.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, the request is latched: ram_addr=req_addr, ram_wdata=req_wdata.
  - Write request: ram_write=1.
  - Read request: ram_read=1, remaining = req_len.
  - Go to ISSUE.
- ISSUE (strobe is live for exactly one cycle):
  - Write: next edge clears ram_write and sets rsp_valid=1, rsp_last=1; rsp_rdata is unchanged; go to RESP.
  - Read: next edge clears ram_read (the RAM captures data at this edge); go to WAIT.
- WAIT:
  - Next edge: rsp_rdata = ram_rdata, rsp_valid=1, rsp_last = (remaining==0); go to RESP.
- RESP:
  - rsp_valid, rsp_rdata and rsp_last hold stable until rsp_valid & rsp_ready at an edge.
  - At that edge rsp_valid and rsp_last clear.
  - If remaining != 0: remaining -= 1, ram_addr = ram_addr+1 (mod 64, 63 wraps to 0), ram_read=1; go to ISSUE.
  - Otherwise go to IDLE.
- Latency:
  - Read: request accept edge E0; first rsp_valid high in the cycle after E0+2.
  - Each further beat: 3 cycles after the previous beat's handshake edge with zero backpressure.
  - Write ack: rsp_valid high in the cycle after E0+1.
- Boundary conditions:
  - ram_write and ram_read are never high together.
  - No RAM strobe is asserted in WAIT, RESP or IDLE.
  - req_ready=0 in every non-IDLE state; requests presented then are not consumed.
  - rsp_ready held high before rsp_valid has no effect.
  - req_len is ignored for writes; they always produce one beat.

Test Plan:
- Reset, then read addr 5, len 0, rsp_ready=1 -> ram_read high for one cycle with ram_addr=5; rsp_rdata=0x0016 (22), rsp_last=1, first seen 3 cycles after accept; req_ready=1 again the next cycle.
- Read burst addr 62, len 3 -> beats 193, 196, 7, 10 (addresses 62, 63, 0, 1); rsp_last high only on the 4th beat.
- Write 0xBEEF to addr 10, then read addr 10 -> write ack has rsp_last=1 and unchanged rsp_rdata; read returns 0xBEEF; ram_write pulses exactly once.
- Read burst addr 0, len 1 with rsp_ready low for 5 cycles on beat 1 -> rsp_valid=1, rsp_rdata=7 stable throughout; no RAM strobe during the stall; beat 2 = 10 after release.
- req_valid held high during a burst -> req_ready=0 and the second request is not accepted until IDLE; it is then served correctly.
- rst_n asserted low in WAIT of a burst -> ram_read, rsp_valid and busy drop to 0 immediately, without a clock; after release a new read of addr 3 returns 16.
